// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, LSB first, one bit per clock.
// Operands are latched on start; a single full-adder cell plus carry flop
// produces the result over WIDTH cycles, followed by a one-cycle DONE state
// that pulses out_valid.
// Optional: define SERIAL_ADDSUB_SAT_EN to saturate sum on signed overflow
// (ovf and cout keep reporting the raw condition).
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb;
  logic [WIDTH-2:0] rres;      // low result bits; the MSB arrives on the last step
  logic             cy;
  logic [CNT_W-1:0] cnt;

  logic             last;
  logic             s_bit, c_nxt, ovf_nxt;
  logic [WIDTH-1:0] res_nxt, sum_nxt;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Full-adder cell and the result word as it will look after this step.
  // On the last bit cy is the carry into the MSB, so cy ^ c_nxt is ovf.
  always_comb begin
    s_bit   = ra[0] ^ rb[0] ^ cy;
    c_nxt   = (ra[0] & rb[0]) | (ra[0] & cy) | (rb[0] & cy);
    res_nxt = {s_bit, rres};
    ovf_nxt = cy ^ c_nxt;
`ifdef SERIAL_ADDSUB_SAT_EN
    // ra[0] is the effective-A MSB when the last bit is processed.
    if (ovf_nxt)
      sum_nxt = ra[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sum_nxt = res_nxt;
`else
    sum_nxt = res_nxt;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result shift registers, carry, counter and held result fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      rres <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        // Subtraction as a + ~b + 1: invert B and seed the carry with 1.
        ra   <= a;
        rb   <= sub ? ~b : b;
        cy   <= sub;
        cnt  <= '0;
      end
    end else if (state == SHIFT) begin
      ra   <= ra >> 1;
      rb   <= rb >> 1;
      rres <= res_nxt[WIDTH-1:1];
      cy   <= c_nxt;
      cnt  <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= sum_nxt;
        cout <= c_nxt;
        ovf  <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: a WIDTH=4 and a WIDTH=8 instance share
// the control inputs; each vector checks latency, busy length, a single
// out_valid pulse, the result fields and that sum holds afterwards.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, sub;
  logic [3:0] a4, b4, sum4;
  logic [7:0] a8, b8, sum8;
  logic       busy4, ov4, cout4, ovf4;
  logic       busy8, ov8, cout8, ovf8;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a4), .b(b4),
    .busy(busy4), .out_valid(ov4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_addsub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a8), .b(b8),
    .busy(busy8), .out_valid(ov8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference signed overflow for 8 bits: carry into MSB xor carry out,
  // taken on the effective operands a and (sub ? ~b : b) with carry-in sub.
  function automatic logic ref_ovf8(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    logic [7:0] bb;
    logic [7:0] lo;
    logic [8:0] full;
    bb   = sv ? ~bv : bv;
    lo   = {1'b0, av[6:0]} + {1'b0, bb[6:0]} + {7'd0, sv};
    full = {1'b0, av} + {1'b0, bb} + {8'd0, sv};
    return lo[7] ^ full[8];
  endfunction

  // One operation on the selected instance. Operands are scrambled every
  // cycle after the start edge; poke re-asserts start while busy.
  task automatic run(input string tag, input int w, input logic [7:0] av, input logic [7:0] bv,
                     input logic sv, input logic [7:0] es, input logic ec, input logic eo,
                     input bit poke);
    int         lat, nbusy, nval;
    logic [7:0] vs, sm;
    logic       vc, vo, bz, ov;
    lat = 0; nbusy = 0; nval = 0; vs = '0; vc = 1'b0; vo = 1'b0;
    @(negedge clk);
    a4 = av[3:0]; b4 = bv[3:0]; a8 = av; b8 = bv; sub = sv; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bz = (w == 4) ? busy4 : busy8;
      ov = (w == 4) ? ov4 : ov8;
      sm = (w == 4) ? {4'd0, sum4} : sum8;
      if (bz) nbusy++;
      if (ov) begin
        nval++;
        lat = k;
        vs  = sm;
        vc  = (w == 4) ? cout4 : cout8;
        vo  = (w == 4) ? ovf4 : ovf8;
      end
      start = poke && (k == 2 || k == 3);
      a4 = 4'($urandom); b4 = 4'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      sub = 1'($urandom);
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(w + 1));
    chk({tag, " busy cycles"}, 32'(nbusy), 32'(w + 1));
    chk({tag, " valid pulses"}, 32'(nval), 32'd1);
    chk({tag, " sum"}, 32'(vs), 32'(es));
    chk({tag, " cout"}, 32'(vc), 32'(ec));
    chk({tag, " ovf"}, 32'(vo), 32'(eo));
    chk({tag, " sum held"}, 32'(sm), 32'(es));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy4), 32'd0);
    chk("reset out_valid", 32'(ov4), 32'd0);
    chk("reset sum", 32'(sum4), 32'd0);
    chk("reset cout", 32'(cout4), 32'd0);
    chk("reset ovf", 32'(ovf4), 32'd0);
    rst = 1'b0;

    // WIDTH=4 directed vectors (sum, cout, ovf hand-computed).
    run("add 1+2", 4, 8'd1, 8'd2, 1'b0, 8'h3, 1'b0, 1'b0, 1'b0);
    run("sub 3-2", 4, 8'd3, 8'd2, 1'b1, 8'h1, 1'b1, 1'b0, 1'b0);
    run("sub 0-1", 4, 8'd0, 8'd1, 1'b1, 8'hF, 1'b0, 1'b0, 1'b0);
    run("sub 5-5", 4, 8'd5, 8'd5, 1'b1, 8'h0, 1'b1, 1'b0, 1'b0);
    run("add 8+8", 4, 8'd8, 8'd8, 1'b0, SAT ? 8'h8 : 8'h0, 1'b1, 1'b1, 1'b0);
    run("sub 8-1", 4, 8'd8, 8'd1, 1'b1, SAT ? 8'h8 : 8'h7, 1'b1, 1'b1, 1'b0);
    run("add 7+1", 4, 8'd7, 8'd1, 1'b0, SAT ? 8'h7 : 8'h8, 1'b0, 1'b1, 1'b0);
    run("busy ignore", 4, 8'd1, 8'd2, 1'b0, 8'h3, 1'b0, 1'b0, 1'b1);
    // Leaves sum4 nonzero for the reset test below.
    run("add 7+1 again", 4, 8'd7, 8'd1, 1'b0, SAT ? 8'h7 : 8'h8, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset two bits into an operation.
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd6; a8 = 8'd5; b8 = 8'd6; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-reset busy", 32'(busy4), 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst busy", 32'(busy4), 32'd0);
    chk("async rst out_valid", 32'(ov4), 32'd0);
    chk("async rst sum", 32'(sum4), 32'd0);
    // start together with rst must not launch an operation.
    start = 1'b1;
    @(negedge clk);
    chk("rst beats start", 32'(busy4), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    run("rst recover 6-3", 4, 8'd6, 8'd3, 1'b1, 8'h3, 1'b1, 1'b0, 1'b0);

    // WIDTH=8 vectors; ovf from the carry-based reference.
    run("w8 200+100", 8, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, ref_ovf8(8'd200, 8'd100, 1'b0), 1'b0);
    run("w8 255+1", 8, 8'd255, 8'd1, 1'b0, 8'd0, 1'b1, ref_ovf8(8'd255, 8'd1, 1'b0), 1'b0);
    run("w8 127+1", 8, 8'd127, 8'd1, 1'b0, SAT ? 8'd127 : 8'd128, 1'b0,
        ref_ovf8(8'd127, 8'd1, 1'b0), 1'b0);
    run("w8 100-200", 8, 8'd100, 8'd200, 1'b1, SAT ? 8'd127 : 8'd156, 1'b0,
        ref_ovf8(8'd100, 8'd200, 1'b1), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
